// File: rtl/t03_icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : t03_icache_pkg
// Description : Shared types and constants for the instruction-cache fetch
//               controller (FSM state encoding, address field positions,
//               NOP instruction and a word-alignment helper).
// Revision    : 1.0 - initial release
// ============================================================================
package t03_icache_pkg;

    localparam int          INDEX_LSB = 2;
    localparam int          INDEX_W   = 4;
    localparam int          TAG_LSB   = 6;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        FILL    = 3'd2,
        TMO     = 3'd3,
        PF_REQ  = 3'd4,
        PF_FILL = 3'd5
    } state_t;

    // Byte offset within the word is never significant to the cache or bus.
    function automatic logic [31:0] word_addr(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/t03_fetch_timer.sv
`default_nettype none
// ============================================================================
// Module      : t03_fetch_timer
// Description : Clearable up-counter measuring cycles spent waiting for a bus
//               acknowledge; o_tc flags the last permitted waiting cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module t03_fetch_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] r_count;

    // Count enabled wait cycles; held at zero while cleared.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_tc = (r_count == W'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/t03_icache_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : t03_icache_fetch_ctrl
// Description : Miss/fill sequencer for a 16-entry direct-mapped I-cache.
//               Serves hits combinationally, fetches misses over a req/ack
//               bus, fills the cache and delivers the word. A bus that never
//               acknowledges yields ERR_INSTR and a sticky bus_error.
//               Optional next-line prefetch: define T03_ICACHE_PREFETCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module t03_icache_fetch_ctrl
    import t03_icache_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_INSTR      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] pc,
    input  logic [31:0] next_pc,
    input  logic        flush,
    input  logic        cache_hit,
    input  logic        cache_next_hit,
    input  logic [31:0] cache_data,
    output logic [31:0] cache_addr,
    output logic [31:0] cache_next_addr,
    output logic        cache_read,
    output logic [31:0] cache_fill_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        stall,
    output logic        bus_error
);

    state_t      r_state,     w_state_nxt;
    logic [31:0] r_miss_addr, w_miss_addr_nxt;
    logic [31:0] r_fill_buf,  w_fill_buf_nxt;
    logic        r_drop,      w_drop_nxt;
    logic        r_bus_error;
    logic        w_set_err;
    logic        w_tmr_clr;
    logic        w_tmr_en;
    logic        w_tmr_tc;
    logic        w_is_pf;

    t03_fetch_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_tmr_clr),
        .i_en    (w_tmr_en),
        .o_tc    (w_tmr_tc)
    );

`ifdef T03_ICACHE_PREFETCH_EN
    assign w_is_pf = (r_state == PF_REQ);
`else
    assign w_is_pf = 1'b0;
    // Prefetch hint is only consumed when prefetch is built in.
    logic w_unused_next_hit;
    assign w_unused_next_hit = cache_next_hit;
`endif

    // Address held stable in the miss register for the whole transaction.
    assign mem_addr        = r_miss_addr;
    assign cache_fill_data = r_fill_buf;
    assign cache_next_addr = next_pc;
    assign bus_error       = r_bus_error;

    // State and datapath registers; bus_error is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
            r_fill_buf  <= '0;
            r_drop      <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_miss_addr <= w_miss_addr_nxt;
            r_fill_buf  <= w_fill_buf_nxt;
            r_drop      <= w_drop_nxt;
            r_bus_error <= r_bus_error | w_set_err;
        end
    end

    // Next-state logic and all combinational outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_miss_addr_nxt = r_miss_addr;
        w_fill_buf_nxt  = r_fill_buf;
        w_drop_nxt      = r_drop;
        w_set_err       = 1'b0;
        w_tmr_clr       = 1'b0;
        w_tmr_en        = 1'b0;
        cache_addr      = pc;
        cache_read      = 1'b0;
        mem_req         = 1'b0;
        instr_out       = '0;
        instr_valid     = 1'b0;
        stall           = 1'b0;

        case (r_state)
            IDLE: begin
                w_drop_nxt = 1'b0;
                w_tmr_clr  = 1'b1;
                if (fetch_req && !flush) begin
                    if (cache_hit) begin
                        instr_out   = cache_data;
                        instr_valid = 1'b1;
`ifdef T03_ICACHE_PREFETCH_EN
                        if (!cache_next_hit && (next_pc[31:2] != pc[31:2])) begin
                            w_miss_addr_nxt = word_addr(next_pc);
                            w_state_nxt     = PF_REQ;
                        end
`endif
                    end else begin
                        w_miss_addr_nxt = word_addr(pc);
                        stall           = 1'b1;
                        w_state_nxt     = REQ;
                    end
                end
            end

`ifdef T03_ICACHE_PREFETCH_EN
            REQ, PF_REQ: begin
`else
            REQ: begin
`endif
                mem_req    = 1'b1;
                cache_addr = r_miss_addr;
                stall      = 1'b1;
                if (flush) begin
                    w_drop_nxt = 1'b1;
                end
                // An acknowledge on the last allowed cycle still wins.
                if (mem_ack) begin
                    w_fill_buf_nxt = mem_rdata;
                    w_state_nxt    = w_is_pf ? PF_FILL : FILL;
                end else if (w_tmr_tc) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = w_is_pf ? IDLE : TMO;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            FILL: begin
                cache_read  = 1'b1;
                cache_addr  = r_miss_addr;
                instr_out   = r_fill_buf;
                instr_valid = !r_drop;
                w_drop_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end

            TMO: begin
                instr_out   = ERR_INSTR;
                instr_valid = !r_drop;
                w_drop_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end

`ifdef T03_ICACHE_PREFETCH_EN
            PF_FILL: begin
                cache_read = 1'b1;
                cache_addr = r_miss_addr;
                // Deliver only if the CPU is already asking for the prefetched word.
                if (fetch_req && (pc[31:2] == r_miss_addr[31:2]) && !flush) begin
                    instr_out   = r_fill_buf;
                    instr_valid = 1'b1;
                end else begin
                    stall = 1'b1;
                end
                w_drop_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
`endif

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_t03_icache_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_t03_icache_fetch_ctrl
// Description : Directed testbench for t03_icache_fetch_ctrl. Expected
//               deliveries are queued by the stimulus and checked by a
//               monitor whenever instr_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t03_icache_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        flush;
    logic        cache_hit;
    logic        cache_next_hit;
    logic [31:0] cache_data;
    logic [31:0] cache_addr;
    logic [31:0] cache_next_addr;
    logic        cache_read;
    logic [31:0] cache_fill_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        stall;
    logic        bus_error;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    t03_icache_fetch_ctrl #(
        .TIMEOUT_CYCLES (4),
        .ERR_INSTR      (32'h0000_0013)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_req       (fetch_req),
        .pc              (pc),
        .next_pc         (next_pc),
        .flush           (flush),
        .cache_hit       (cache_hit),
        .cache_next_hit  (cache_next_hit),
        .cache_data      (cache_data),
        .cache_addr      (cache_addr),
        .cache_next_addr (cache_next_addr),
        .cache_read      (cache_read),
        .cache_fill_data (cache_fill_data),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .instr_out       (instr_out),
        .instr_valid     (instr_valid),
        .stall           (stall),
        .bus_error       (bus_error)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every delivered instruction must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (instr_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got instr %h want no delivery", instr_out);
                end else begin
                    chk("instr_out", instr_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; fetch_req = 1'b0; pc = '0; next_pc = '0; flush = 1'b0;
        cache_hit = 1'b0; cache_next_hit = 1'b1; cache_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        repeat (2) step();
        rst = 1'b0;
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        chk("rst_cache_read", 32'(cache_read), 32'd0);

        // Zero-latency hit
        step();
        pc = 32'h200; next_pc = 32'h204; fetch_req = 1'b1;
        cache_hit = 1'b1; cache_data = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        #2;
        chk("hit_stall", 32'(stall), 32'd0);
        chk("hit_mem_req", 32'(mem_req), 32'd0);
        chk("hit_cache_addr", cache_addr, 32'h200);
        step();
        fetch_req = 1'b0; cache_hit = 1'b0;
        #2;
        chk("hit_after_mem_req", 32'(mem_req), 32'd0);

        // Miss with ack in the third request cycle
        step();
        pc = 32'h44; next_pc = 32'h48; fetch_req = 1'b1;
        #2;
        chk("miss_stall_now", 32'(stall), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            step();
            if (i == 3) begin
                mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
            end
            #2;
            chk("miss_mem_req", 32'(mem_req), 32'd1);
            chk("miss_mem_addr", mem_addr, 32'h44);
            chk("miss_stall", 32'(stall), 32'd1);
        end
        step();
        mem_ack = 1'b0; mem_rdata = '0;
        exp_q.push_back(32'h1234_5678);
        #2;
        chk("fill_cache_read", 32'(cache_read), 32'd1);
        chk("fill_data", cache_fill_data, 32'h1234_5678);
        chk("fill_cache_addr", cache_addr, 32'h44);
        chk("fill_stall", 32'(stall), 32'd0);
        step();
        fetch_req = 1'b0;
        #2;
        chk("post_fill_stall", 32'(stall), 32'd0);
        chk("post_fill_cache_read", 32'(cache_read), 32'd0);
        chk("post_fill_mem_req", 32'(mem_req), 32'd0);

        // Flush during request; ack lands on the last allowed cycle
        step();
        pc = 32'h80; fetch_req = 1'b1;
        step();
        flush = 1'b1; fetch_req = 1'b0;
        #2;
        chk("flush_mem_addr", mem_addr, 32'h80);
        step();
        flush = 1'b0;
        step();
        step();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #2;
        chk("flush_req4_mem_req", 32'(mem_req), 32'd1);
        step();
        mem_ack = 1'b0;
        #2;
        chk("flush_cache_read", 32'(cache_read), 32'd1);
        chk("flush_fill_data", cache_fill_data, 32'hCAFE_F00D);
        chk("flush_valid", 32'(instr_valid), 32'd0);
        step();
        #2;
        chk("flush_idle_mem_req", 32'(mem_req), 32'd0);
        chk("flush_idle_stall", 32'(stall), 32'd0);
        chk("flush_no_err", 32'(bus_error), 32'd0);

        // Zero fill word, unaligned pc
        step();
        pc = 32'h4B; fetch_req = 1'b1;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h0;
        #2;
        chk("unaligned_mem_addr", mem_addr, 32'h48);
        step();
        mem_ack = 1'b0;
        exp_q.push_back(32'h0);
        #2;
        chk("zero_cache_read", 32'(cache_read), 32'd1);
        step();
        fetch_req = 1'b0;

        // Timeout after four unacknowledged request cycles
        step();
        pc = 32'h300; fetch_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            #2;
            chk("tmo_mem_req", 32'(mem_req), 32'd1);
        end
        step();
        exp_q.push_back(32'h0000_0013);
        #2;
        chk("tmo_bus_error", 32'(bus_error), 32'd1);
        chk("tmo_cache_read", 32'(cache_read), 32'd0);
        chk("tmo_stall", 32'(stall), 32'd0);
        step();
        fetch_req = 1'b0; mem_ack = 1'b1;
        #2;
        chk("late_ack_err_sticky", 32'(bus_error), 32'd1);
        chk("late_ack_cache_read", 32'(cache_read), 32'd0);
        step();
        mem_ack = 1'b0;
        #2;
        chk("late_ack_mem_req", 32'(mem_req), 32'd0);
        chk("late_ack_stall", 32'(stall), 32'd0);

        // Reset during a miss
        step();
        pc = 32'h400; fetch_req = 1'b1;
        step();
        #2;
        chk("rstmid_mem_req_before", 32'(mem_req), 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; fetch_req = 1'b0;
        #2;
        chk("rstmid_mem_req", 32'(mem_req), 32'd0);
        chk("rstmid_err_cleared", 32'(bus_error), 32'd0);
        step();
        mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD;
        #2;
        chk("stray_ack_cache_read", 32'(cache_read), 32'd0);
        step();
        mem_ack = 1'b0;
        #2;
        chk("stray_ack_cache_read2", 32'(cache_read), 32'd0);
        chk("stray_ack_mem_req", 32'(mem_req), 32'd0);

`ifdef T03_ICACHE_PREFETCH_EN
        // Next-line prefetch delivered when the CPU arrives at it
        step();
        pc = 32'h100; next_pc = 32'h104; fetch_req = 1'b1;
        cache_hit = 1'b1; cache_next_hit = 1'b0; cache_data = 32'h1111_1111;
        exp_q.push_back(32'h1111_1111);
        step();
        pc = 32'h104; next_pc = 32'h108; cache_hit = 1'b0; cache_next_hit = 1'b1;
        #2;
        chk("pf_mem_addr", mem_addr, 32'h104);
        chk("pf_mem_req", 32'(mem_req), 32'd1);
        chk("pf_stall", 32'(stall), 32'd1);
        step();
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        step();
        mem_ack = 1'b0;
        exp_q.push_back(32'hA5A5_A5A5);
        #2;
        chk("pf_cache_read", 32'(cache_read), 32'd1);
        chk("pf_stall_deliver", 32'(stall), 32'd0);
        step();
        fetch_req = 1'b0;
`endif

        step();
        step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
